muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_sign_adj.sv | 50 +++++
 rtl/muldiv_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MULT/DIV sequencer.
// Optional signed support is selected with the SIGNED_MULDIV_EN macro.
package muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int ITERS_DEFAULT = 32;

  // Opcodes understood by the single-cycle EX-stage ALU
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_LUI = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  // Request encodings on req_op
  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } req_op_t;

  // Sequencer states; FIX exists only when signed fix-up is built in
  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_CMP,
    DIV_SUB,
`ifdef SIGNED_MULDIV_EN
    FIX,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_sign_adj.sv
// Signed operand/result adjustment for muldiv_seq (used with SIGNED_MULDIV_EN).
// Takes magnitudes of incoming operands and re-applies signs to the raw
// unsigned HI/LO result, using its own negators rather than the shared ALU.
module muldiv_sign_adj
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            op_signed,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  input  logic            is_mul,
  input  logic            neg_a,
  input  logic            neg_b,
  input  logic [XLEN-1:0] res_hi,
  input  logic [XLEN-1:0] res_lo,
  output logic [XLEN-1:0] fix_hi,
  output logic [XLEN-1:0] fix_lo
);

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_neg;

  assign prod     = {res_hi, res_lo};
  assign prod_neg = ~prod + (2*XLEN)'(1);

  // Operand magnitudes; the most negative value maps onto itself as unsigned
  always_comb begin
    mag_a = (op_signed && op_a[XLEN-1]) ? (~op_a + XLEN'(1)) : op_a;
    mag_b = (op_signed && op_b[XLEN-1]) ? (~op_b + XLEN'(1)) : op_b;
  end

  // Result signs: product/quotient follow the sign mismatch, remainder the dividend
  always_comb begin
    fix_hi = res_hi;
    fix_lo = res_lo;
    if (is_mul) begin
      if (neg_a ^ neg_b) begin
        fix_hi = prod_neg[2*XLEN-1:XLEN];
        fix_lo = prod_neg[XLEN-1:0];
      end
    end else begin
      if (neg_a ^ neg_b) fix_lo = ~res_lo + XLEN'(1);
      if (neg_a)         fix_hi = ~res_hi + XLEN'(1);
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer for the EX stage. Borrows the pipeline ALU
// for one add/compare/subtract per cycle and owns the HI/LO registers.
// Define SIGNED_MULDIV_EN to honour req_signed (adds a FIX state).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            alu_own,
  output logic [2:0]      alu_opcode,
  output logic [XLEN-1:0] alu_rs,
  output logic [XLEN-1:0] alu_rt,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_t state, state_nxt, fin_state;

  // wk_hi is the accumulator (MULT) or remainder (DIV); wk_lo is the
  // multiplier (MULT) or quotient (DIV); opnd is multiplicand or divisor
  logic [XLEN-1:0] wk_hi, wk_lo, opnd, rsh;
  logic            ge, dbz;
  logic [CNT_W-1:0] cnt;
  logic            last;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            mul_carry;
  logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt, div_r, rem_nxt, quo_nxt;
  logic            fin_fix;

  assign last       = (cnt == CNT_LAST);
  assign mul_carry  = (alu_out < wk_hi);
  assign mul_hi_nxt = {mul_carry, alu_out[XLEN-1:1]};
  assign mul_lo_nxt = {alu_out[0], wk_lo[XLEN-1:1]};
  assign div_r      = {wk_hi[XLEN-2:0], wk_lo[XLEN-1]};
  assign rem_nxt    = ge ? alu_out : rsh;
  assign quo_nxt    = {wk_lo[XLEN-2:0], ge};

`ifdef SIGNED_MULDIV_EN
  logic            sgn_op, sgn_a, sgn_b, op_mul;
  logic [XLEN-1:0] fix_hi, fix_lo;

  muldiv_sign_adj #(.XLEN(XLEN)) u_sign_adj (
    .op_signed (req_signed),
    .op_a      (req_a),
    .op_b      (req_b),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .is_mul    (op_mul),
    .neg_a     (sgn_a),
    .neg_b     (sgn_b),
    .res_hi    (wk_hi),
    .res_lo    (wk_lo),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  assign fin_fix   = sgn_op;
  assign fin_state = sgn_op ? FIX : DONE;

  // Remember operand signs of the accepted MULT/DIV for the final fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_op <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      op_mul <= 1'b0;
    end else if (req_valid && state == IDLE && (req_op == OP_MULT || req_op == OP_DIV)) begin
      sgn_op <= req_signed;
      sgn_a  <= req_signed & req_a[XLEN-1];
      sgn_b  <= req_signed & req_b[XLEN-1];
      op_mul <= (req_op == OP_MULT);
    end
  end
`else
  logic unused_signed;

  assign unused_signed = req_signed;
  assign mag_a         = req_a;
  assign mag_b         = req_b;
  assign fin_fix       = 1'b0;
  assign fin_state     = DONE;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: MTHI/MTLO stay in IDLE, DIV by zero skips straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_op == OP_MULT)     state_nxt = MUL;
          else if (req_op == OP_DIV) state_nxt = (req_b == '0) ? DONE : DIV_CMP;
        end
      end
      MUL:     if (last) state_nxt = fin_state;
      DIV_CMP: state_nxt = DIV_SUB;
      DIV_SUB: state_nxt = last ? fin_state : DIV_CMP;
`ifdef SIGNED_MULDIV_EN
      FIX:     state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU borrowing and handshake outputs, decoded from the current state
  always_comb begin
    alu_own    = 1'b0;
    alu_opcode = ALU_AND;
    alu_rs     = '0;
    alu_rt     = '0;
    case (state)
      MUL: begin
        alu_own    = 1'b1;
        alu_opcode = ALU_ADD;
        alu_rs     = wk_hi;
        alu_rt     = wk_lo[0] ? opnd : '0;
      end
      DIV_CMP: begin
        alu_own    = 1'b1;
        alu_opcode = ALU_SLT;
        alu_rs     = div_r;
        alu_rt     = opnd;
      end
      DIV_SUB: begin
        alu_own    = 1'b1;
        alu_opcode = ge ? ALU_SUB : ALU_AND;
        alu_rs     = rsh;
        alu_rt     = opnd;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign done        = (state == DONE);
  assign div_by_zero = (state == DONE) & dbz;

  // Datapath: operand capture, per-iteration update, HI/LO commit at completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      wk_hi <= '0;
      wk_lo <= '0;
      opnd  <= '0;
      rsh   <= '0;
      ge    <= 1'b0;
      dbz   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            case (req_op)
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              OP_MULT: begin
                wk_hi <= '0;
                wk_lo <= mag_b;
                opnd  <= mag_a;
                cnt   <= '0;
                dbz   <= 1'b0;
              end
              default: begin
                wk_hi <= '0;
                wk_lo <= mag_a;
                opnd  <= mag_b;
                cnt   <= '0;
                dbz   <= (req_b == '0);
              end
            endcase
          end
        end
        MUL: begin
          wk_hi <= mul_hi_nxt;
          wk_lo <= mul_lo_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last && !fin_fix) begin
            hi <= mul_hi_nxt;
            lo <= mul_lo_nxt;
          end
        end
        DIV_CMP: begin
          rsh <= div_r;
          ge  <= wk_hi[XLEN-1] | ~alu_out[0];
        end
        DIV_SUB: begin
          wk_hi <= rem_nxt;
          wk_lo <= quo_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last && !fin_fix) begin
            hi <= rem_nxt;
            lo <= quo_nxt;
          end
        end
`ifdef SIGNED_MULDIV_EN
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq with a behavioural EX-stage ALU.
// Signed checks are included when SIGNED_MULDIV_EN is defined.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid, req_ready, req_signed;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a, req_b;
  logic            alu_own;
  logic [2:0]      alu_opcode;
  logic [XLEN-1:0] alu_rs, alu_rt, alu_out;
  logic [XLEN-1:0] hi, lo;
  logic            done, div_by_zero;

  int checks = 0;
  int failures = 0;

  // Observations gathered while waiting for an operation to finish
  int   doneCyc, ownCount, ownFirst, ownLast, opErr, readyBusy;
  logic dbzAtDone, readyAfter;
  int   readyLow, doneSeen;

  muldiv_seq #(.XLEN(XLEN), .ITERS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_signed  (req_signed),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_own     (alu_own),
    .alu_opcode  (alu_opcode),
    .alu_rs      (alu_rs),
    .alu_rt      (alu_rt),
    .alu_out     (alu_out),
    .hi          (hi),
    .lo          (lo),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Behavioural single-cycle pipeline ALU answering in the same cycle
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_out = alu_rs & alu_rt;
      3'b001:  alu_out = alu_rs | alu_rt;
      3'b010:  alu_out = alu_rs + alu_rt;
      3'b011:  alu_out = {alu_rt[15:0], 16'h0000};
      3'b110:  alu_out = alu_rs - alu_rt;
      3'b111:  alu_out = {31'd0, (alu_rs < alu_rt)};
      default: alu_out = '0;
    endcase
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request for a single accept edge, then scramble the inputs
  task automatic applyStimulus(input logic [1:0] op, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_op     = op;
    req_signed = sgn;
    req_a      = a;
    req_b      = b;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_op     = OP_MTHI;
    req_signed = 1'b0;
    req_a      = 32'hDEADBEEF;
    req_b      = 32'h0;
  endtask

  // Follow an accepted operation cycle by cycle, bounded by maxCyc
  task automatic waitDone(input int maxCyc, input bit isDiv);
    doneCyc = -1; ownCount = 0; ownFirst = 0; ownLast = 0; opErr = 0;
    readyBusy = 0; dbzAtDone = 1'b0;
    for (int k = 1; k <= maxCyc; k++) begin
      @(negedge clk);
      if (req_ready) readyBusy++;
      if (alu_own) begin
        ownCount++;
        if (ownFirst == 0) ownFirst = k;
        ownLast = k;
        if (isDiv) begin
          if (k % 2 == 1) begin
            if (alu_opcode != 3'b111) opErr++;
          end else if (!(alu_opcode == 3'b110 || alu_opcode == 3'b000)) begin
            opErr++;
          end
        end
      end
      if (done) begin
        doneCyc   = k;
        dbzAtDone = div_by_zero;
        break;
      end
    end
    @(negedge clk);
    readyAfter = req_ready;
  endtask

  // MTHI followed immediately by MTLO, watching ready and done throughout
  task automatic moveHiLo(input logic [31:0] hv, input logic [31:0] lv);
    readyLow = 0; doneSeen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_MTHI; req_a = hv;
    @(negedge clk);
    readyLow += int'(!req_ready); doneSeen += int'(done);
    @(posedge clk); #1;
    req_op = OP_MTLO; req_a = lv;
    @(negedge clk);
    readyLow += int'(!req_ready); doneSeen += int'(done);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    readyLow += int'(!req_ready); doneSeen += int'(done);
  endtask

  initial begin
    req_valid = 1'b0; req_op = OP_MULT; req_signed = 1'b0;
    req_a = '0; req_b = '0;

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hi", hi, 64'h0);
    checkOutput("rst_lo", lo, 64'h0);
    checkOutput("rst_ready", req_ready, 64'h1);
    checkOutput("rst_done_dbz", {done, div_by_zero}, 64'h0);
    checkOutput("rst_alu", {alu_own, alu_opcode, alu_rs, alu_rt}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Largest unsigned product, latency and ALU ownership window
    applyStimulus(OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(40, 1'b0);
    checkOutput("mul_done_cyc", doneCyc, 33);
    checkOutput("mul_hi", hi, 64'hFFFFFFFE);
    checkOutput("mul_lo", lo, 64'h00000001);
    checkOutput("mul_own_cnt", ownCount, 32);
    checkOutput("mul_own_first", ownFirst, 1);
    checkOutput("mul_own_last", ownLast, 32);
    checkOutput("mul_ready_busy", readyBusy, 0);
    checkOutput("mul_ready_after", readyAfter, 64'h1);
    checkOutput("mul_no_dbz", dbzAtDone, 64'h0);

    // Plain division with remainder and opcode alternation
    applyStimulus(OP_DIV, 1'b0, 32'd100, 32'd7);
    waitDone(80, 1'b1);
    checkOutput("div_done_cyc", doneCyc, 65);
    checkOutput("div_lo", lo, 64'd14);
    checkOutput("div_hi", hi, 64'd2);
    checkOutput("div_opcode_seq", opErr, 0);
    checkOutput("div_own_cnt", ownCount, 64);
    checkOutput("div_no_dbz", dbzAtDone, 64'h0);

    // Divide by zero leaves preloaded HI/LO alone
    moveHiLo(32'hAA, 32'hBB);
    checkOutput("pre_hi", hi, 64'hAA);
    checkOutput("pre_lo", lo, 64'hBB);
    applyStimulus(OP_DIV, 1'b0, 32'd5, 32'd0);
    waitDone(10, 1'b0);
    checkOutput("dbz_done_cyc", doneCyc, 1);
    checkOutput("dbz_flag", dbzAtDone, 64'h1);
    checkOutput("dbz_hi", hi, 64'hAA);
    checkOutput("dbz_lo", lo, 64'hBB);
    checkOutput("dbz_ready_after", readyAfter, 64'h1);

    // Back-to-back MTHI/MTLO
    moveHiLo(32'h1234, 32'h5678);
    checkOutput("mt_hi", hi, 64'h1234);
    checkOutput("mt_lo", lo, 64'h5678);
    checkOutput("mt_ready_held", readyLow, 0);
    checkOutput("mt_no_done", doneSeen, 0);

    // Reset in the middle of a MULT aborts it and clears HI/LO
    applyStimulus(OP_MULT, 1'b0, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_hi", hi, 64'h0);
    checkOutput("abort_lo", lo, 64'h0);
    checkOutput("abort_own", alu_own, 64'h0);
    checkOutput("abort_ready", req_ready, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(OP_MULT, 1'b0, 32'd3, 32'd4);
    waitDone(40, 1'b0);
    checkOutput("mul3x4_done_cyc", doneCyc, 33);
    checkOutput("mul3x4_lo", lo, 64'd12);
    checkOutput("mul3x4_hi", hi, 64'd0);

    // Carry out of the low word and a dividend smaller than the divisor
    applyStimulus(OP_MULT, 1'b0, 32'hFFFFFFFF, 32'd2);
    waitDone(40, 1'b0);
    checkOutput("mulx2_hi", hi, 64'h1);
    checkOutput("mulx2_lo", lo, 64'hFFFFFFFE);
    applyStimulus(OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    waitDone(80, 1'b1);
    checkOutput("divu_big_lo", lo, 64'h0);
    checkOutput("divu_big_hi", hi, 64'h80000000);

`ifdef SIGNED_MULDIV_EN
    // Signed operations go through the extra fix-up cycle
    applyStimulus(OP_MULT, 1'b1, 32'hFFFFFFFA, 32'd7);
    waitDone(40, 1'b0);
    checkOutput("smul_done_cyc", doneCyc, 34);
    checkOutput("smul_hi", hi, 64'hFFFFFFFF);
    checkOutput("smul_lo", lo, 64'hFFFFFFD6);
    applyStimulus(OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2);
    waitDone(80, 1'b1);
    checkOutput("sdiv_done_cyc", doneCyc, 66);
    checkOutput("sdiv_lo", lo, 64'hFFFFFFFD);
    checkOutput("sdiv_hi", hi, 64'hFFFFFFFF);
    applyStimulus(OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    waitDone(80, 1'b1);
    checkOutput("sdiv_ovf_lo", lo, 64'h80000000);
    checkOutput("sdiv_ovf_hi", hi, 64'h0);
`else
    // req_signed has no effect: the operands are treated as unsigned
    applyStimulus(OP_MULT, 1'b1, 32'hFFFFFFFA, 32'd7);
    waitDone(40, 1'b0);
    checkOutput("usig_done_cyc", doneCyc, 33);
    checkOutput("usig_hi", hi, 64'h6);
    checkOutput("usig_lo", lo, 64'hFFFFFFD6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
